// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that shares one 4:1 output channel among four requesters.
// A grant lasts until the owner drops req or HOLD_MAX beats are accepted.
module rr_mux_arbiter #(
  parameter int WIDTH    = 4,
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic             out_ready,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  state_t           state;
  logic [1:0]       last;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] data_sel;
  logic             busy;
  logic             xfer;
  logic             rel;
  logic [1:0]       winner;

  // Scan from farthest to nearest so the requester right after prev wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] prev, input logic [3:0] r);
    logic [1:0] idx;
    rr_pick = prev;
    for (int i = 4; i >= 1; i--) begin
      idx = prev + 2'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    data_sel = in1;
    case (sel)
      2'd0: data_sel = in1;
      2'd1: data_sel = in2;
      2'd2: data_sel = in3;
      2'd3: data_sel = in4;
      default: data_sel = in1;
    endcase
  end

  assign busy      = (state == BUSY);
  assign out       = busy ? data_sel : '0;
  assign out_valid = busy && req[sel];
  assign xfer      = out_valid && out_ready;
  assign rel       = busy && (!req[sel] || (xfer && (cnt == HOLD_LAST)));
  // On release the current owner becomes the lowest-priority requester.
  assign winner    = rr_pick(busy ? sel : last, req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
      last  <= 2'd3;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state <= BUSY;
            sel   <= winner;
            gnt   <= 4'b0001 << winner;
            cnt   <= 4'd0;
          end
        end
        BUSY: begin
          if (rel) begin
            last <= sel;
            cnt  <= 4'd0;
            if (|req) begin
              sel <= winner;
              gnt <= 4'b0001 << winner;
            end else begin
              state <= IDLE;
              gnt   <= 4'b0000;
            end
          end else if (xfer) begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: HOLD_MAX=4 main instance, HOLD_MAX=2 for the
// sole-requester re-win case.
module tb_rr_mux_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] in1, in2, in3, in4;
  logic       out_ready;
  logic [3:0] gnt, gnt2;
  logic [1:0] sel, sel2;
  logic [3:0] out, out2;
  logic       out_valid, out_valid2;

  int n_chk  = 0;
  int n_fail = 0;
  int beats;
  logic [3:0] dv [4];
  logic [1:0] exp_sel;

  rr_mux_arbiter #(.WIDTH(4), .HOLD_MAX(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .out_ready(out_ready),
    .gnt(gnt), .sel(sel), .out(out), .out_valid(out_valid)
  );

  rr_mux_arbiter #(.WIDTH(4), .HOLD_MAX(2)) dut2 (
    .clk(clk), .rst(rst), .req(req),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .out_ready(out_ready),
    .gnt(gnt2), .sel(sel2), .out(out2), .out_valid(out_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req = 4'b0000; out_ready = 1'b0;
    in1 = 4'h3; in2 = 4'h6; in3 = 4'h9; in4 = 4'hC;
    dv[0] = 4'h3; dv[1] = 4'h6; dv[2] = 4'h9; dv[3] = 4'hC;
    #1 rst = 1'b1;
    #2;
    chk("rst_gnt", 8'(gnt), 8'h0);
    chk("rst_sel", 8'(sel), 8'h0);
    chk("rst_out", 8'(out), 8'h0);
    chk("rst_valid", 8'(out_valid), 8'h0);
    tick(); tick();
    rst = 1'b0;

    // 1: single requester, 4 beats, then idle once it drops req
    req = 4'b0001; out_ready = 1'b1;
    #1 chk("t1_gnt_pre", 8'(gnt), 8'h0);
    tick();
    chk("t1_gnt", 8'(gnt), 8'h1);
    chk("t1_sel", 8'(sel), 8'h0);
    chk("t1_out", 8'(out), 8'h3);
    chk("t1_valid", 8'(out_valid), 8'h1);
    beats = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid && out_ready) beats++;
      chk($sformatf("t1_hold%0d", i), 8'(gnt), 8'h1);
      tick();
    end
    chk("t1_beats", 8'(beats), 8'd4);
    req = 4'b0000;
    #1 chk("t1_drop_valid", 8'(out_valid), 8'h0);
    tick();
    chk("t1_idle_gnt", 8'(gnt), 8'h0);
    chk("t1_idle_out", 8'(out), 8'h0);

    // 2: all requesting, grants rotate 0,1,2,3,0 with 4 beats each, no bubble
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 21; k++) begin
      exp_sel = 2'((k / 4) % 4);
      chk($sformatf("t2_sel%0d", k), 8'(sel), 8'(exp_sel));
      chk($sformatf("t2_gnt%0d", k), 8'(gnt), 8'(4'b0001 << exp_sel));
      chk($sformatf("t2_out%0d", k), 8'(out), 8'(dv[exp_sel]));
      chk($sformatf("t2_valid%0d", k), 8'(out_valid), 8'h1);
      tick();
    end

    // 3: stall holds grant and beat count
    do_reset();
    req = 4'b0010; out_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_stall_valid%0d", i), 8'(out_valid), 8'h1);
      chk($sformatf("t3_stall_out%0d", i), 8'(out), 8'h6);
      chk($sformatf("t3_stall_gnt%0d", i), 8'(gnt), 8'h2);
      tick();
    end
    out_ready = 1'b1; req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_run_gnt%0d", i), 8'(gnt), 8'h2);
      tick();
    end
    chk("t3_next_gnt", 8'(gnt), 8'h1);
    chk("t3_next_sel", 8'(sel), 8'h0);

    // 4: owner drops req after 2 beats, handoff to requester 3
    do_reset();
    req = 4'b1100; out_ready = 1'b1;
    tick();
    chk("t4_gnt", 8'(gnt), 8'h4);
    chk("t4_out", 8'(out), 8'h9);
    tick(); tick();
    req = 4'b1000;
    #1 chk("t4_drop_valid", 8'(out_valid), 8'h0);
    tick();
    chk("t4_hand_gnt", 8'(gnt), 8'h8);
    chk("t4_hand_sel", 8'(sel), 8'h3);
    chk("t4_hand_out", 8'(out), 8'hC);

    // 5: HOLD_MAX=2, sole requester re-wins and its count restarts
    do_reset();
    req = 4'b0100;
    tick();
    chk("t5_gnt_w1", 8'(gnt2), 8'h4);
    tick();
    chk("t5_gnt_w2", 8'(gnt2), 8'h4);
    tick();
    chk("t5_gnt_rewin", 8'(gnt2), 8'h4);
    chk("t5_valid_rewin", 8'(out_valid2), 8'h1);
    req = 4'b1100;
    tick();
    chk("t5_gnt_w4", 8'(gnt2), 8'h4);
    tick();
    chk("t5_gnt_next", 8'(gnt2), 8'h8);
    chk("t5_sel_next", 8'(sel2), 8'h3);

    // 6: async reset mid-burst, then requester 0 gets first grant
    do_reset();
    req = 4'b0010;
    tick();
    chk("t6_gnt", 8'(gnt), 8'h2);
    tick(); tick();
    req = 4'b1111;
    #1 chk("t6_other_req_gnt", 8'(gnt), 8'h2);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_gnt", 8'(gnt), 8'h0);
    chk("t6_rst_sel", 8'(sel), 8'h0);
    chk("t6_rst_out", 8'(out), 8'h0);
    chk("t6_rst_valid", 8'(out_valid), 8'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_first_gnt", 8'(gnt), 8'h1);
    chk("t6_first_sel", 8'(sel), 8'h0);
    chk("t6_first_out", 8'(out), 8'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
